// File: rtl/timestep_sequencer.sv
// timestep_sequencer: timestep controller for the spike-driven MAC array.
// Holds set_mac for INIT_CYCLES, then per timestep round-robin arbitrates
// spike requests onto source_address (one per cycle), pulses clear_mac for
// CLEAR_CYCLES, and waits for accum_done before the next timestep.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   start, stop       : start from IDLE / return to IDLE after a timestep
//   spike_req/addr    : per-requester request and packed address
//   spike_grant       : registered one-hot grant (one cycle)
//   set_mac,clear_mac : MAC init / end-of-timestep strobes
//   source_address/valid : broadcast spike address and its qualifier
//   accum_done        : downstream accumulation complete (level)
//   timestep_end      : one-cycle pulse per completed timestep
//   timestep_count    : completed timesteps (wrapping)
//   busy              : state is not IDLE
module timestep_sequencer #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned ADDR_BITS       = 12,
  parameter int unsigned TIMESTEP_CYCLES = 64,
  parameter int unsigned INIT_CYCLES     = 4,
  parameter int unsigned CLEAR_CYCLES    = 2,
  parameter logic [ADDR_BITS-1:0] IDLE_ADDR = {ADDR_BITS{1'b1}}
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           stop,
  input  logic [NUM_REQ-1:0]             spike_req,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   spike_addr,
  output logic [NUM_REQ-1:0]             spike_grant,
  output logic                           set_mac,
  output logic                           clear_mac,
  output logic [ADDR_BITS-1:0]           source_address,
  output logic                           source_valid,
  input  logic                           accum_done,
  output logic                           timestep_end,
  output logic [15:0]                    timestep_count,
  output logic                           busy
);

  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned MAX_IC  = (INIT_CYCLES > CLEAR_CYCLES) ? INIT_CYCLES : CLEAR_CYCLES;
  localparam int unsigned MAX_CNT = (TIMESTEP_CYCLES > MAX_IC) ? TIMESTEP_CYCLES : MAX_IC;
  localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_RUN, S_CLEAR, S_WAIT_DONE
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       rr_ptr;

  logic [ADDR_BITS-1:0]   addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0]     elig;
  logic [IDX_W:0]         cand_sum;
  logic [IDX_W-1:0]       cand;
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W:0]         ptr_sum;
  logic [IDX_W-1:0]       next_ptr;

  // Unpack the flat address bus into one entry per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = spike_addr[gi*ADDR_BITS +: ADDR_BITS];
  end

  // Round-robin pick starting at rr_ptr; requesters granted this cycle are masked.
  always_comb begin
    elig      = spike_req & ~spike_grant;
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand_sum >= (IDX_W+1)'(NUM_REQ)) cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
      cand = cand_sum[IDX_W-1:0];
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    ptr_sum  = {1'b0, win_idx} + (IDX_W+1)'(1);
    next_ptr = (ptr_sum == (IDX_W+1)'(NUM_REQ)) ? '0 : ptr_sum[IDX_W-1:0];
  end

  // Phase FSM with registered strobes, grant and broadcast outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      rr_ptr         <= '0;
      spike_grant    <= '0;
      set_mac        <= 1'b0;
      clear_mac      <= 1'b0;
      source_address <= IDLE_ADDR;
      source_valid   <= 1'b0;
      timestep_end   <= 1'b0;
      timestep_count <= '0;
      busy           <= 1'b0;
    end else begin
      spike_grant    <= '0;
      source_valid   <= 1'b0;
      source_address <= IDLE_ADDR;
      timestep_end   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_INIT;
            set_mac <= 1'b1;
            busy    <= 1'b1;
            cnt     <= '0;
          end
        end
        S_INIT: begin
          if (cnt == CNT_W'(INIT_CYCLES - 1)) begin
            set_mac <= 1'b0;
            state   <= S_RUN;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          // Last phase slot issues no grant so the bus is quiet entering CLEAR.
          if (cnt == CNT_W'(TIMESTEP_CYCLES - 1)) begin
            state     <= S_CLEAR;
            clear_mac <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (win_found) begin
              spike_grant    <= NUM_REQ'(1) << win_idx;
              source_address <= addr_arr[win_idx];
              source_valid   <= 1'b1;
              rr_ptr         <= next_ptr;
            end
          end
        end
        S_CLEAR: begin
          if (cnt == CNT_W'(CLEAR_CYCLES - 1)) begin
            clear_mac <= 1'b0;
            state     <= S_WAIT_DONE;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (accum_done) begin
            timestep_end   <= 1'b1;
            timestep_count <= timestep_count + 16'd1;
            cnt            <= '0;
            if (stop) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_RUN;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
